// File: rtl/qbert_pkg.sv
// Shared types and default pyramid geometry for the Q*bert hop controller and cube renderer.
// Screen x grows down the pyramid (row axis), screen y grows along a row (col axis).
package qbert_pkg;

    typedef enum logic [1:0] {
        UL = 2'd0,
        UR = 2'd1,
        DL = 2'd2,
        DR = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TARGET = 3'd1,
        MOVE_Y = 3'd2,
        MOVE_X = 3'd3,
        LAND   = 3'd4,
        FALL   = 3'd5
    } jstate_t;

    localparam int          N_ROWS_DEF   = 7;
    localparam logic [10:0] X_TOP_DEF    = 11'd100;
    localparam logic [9:0]  Y_TOP_DEF    = 10'd400;
    localparam logic [10:0] XDIAG_DEF    = 11'd60;
    localparam logic [9:0]  YDIAG_DEF    = 10'd100;
    localparam int          TICK_DIV_DEF = 65536;
    localparam logic [10:0] FALL_PIX_DEF = 11'd120;

    function automatic logic is_down(dir_t d);
        return d[1];
    endfunction

endpackage

// File: rtl/qbert_jump_ctrl_if.sv
// Jump command and sprite position bundle between the game logic and the hop controller.
interface qbert_jump_ctrl_if;
    logic        jump_req;
    logic [1:0]  jump_dir;
    logic [10:0] qbert_x;
    logic [9:0]  qbert_y;
    logic [2:0]  cube_row;
    logic [2:0]  cube_col;
    logic        busy;
    logic        landed;
    logic        fell;

    modport master (
        output jump_req, jump_dir,
        input  qbert_x, qbert_y, cube_row, cube_col, busy, landed, fell
    );

    modport slave (
        input  jump_req, jump_dir,
        output qbert_x, qbert_y, cube_row, cube_col, busy, landed, fell
    );
endinterface

// File: rtl/qbert_cube_pos.sv
// Combinational cube (row, col) to centre-pixel mapper; also used by the cube renderer.
// Zero latency; no handshake.
module qbert_cube_pos
    import qbert_pkg::*;
#(
    parameter logic [10:0] X_TOP = X_TOP_DEF,
    parameter logic [9:0]  Y_TOP = Y_TOP_DEF,
    parameter logic [10:0] XDIAG = XDIAG_DEF,
    parameter logic [9:0]  YDIAG = YDIAG_DEF
) (
    input  logic [2:0]  row,
    input  logic [2:0]  col,
    output logic [10:0] x,
    output logic [9:0]  y
);
    logic [11:0] x_w;
    logic [11:0] y_w;

    always_comb begin
        x_w = 12'(X_TOP) + 12'(row) * 12'(XDIAG);
        y_w = 12'(Y_TOP) + 12'(col) * 12'(YDIAG) - 12'(row) * 12'(YDIAG >> 1);
    end

    assign x = x_w[10:0];
    assign y = y_w[9:0];
endmodule

// File: rtl/qbert_jump_ctrl.sv
// Q*bert hop sequencer: moves the sprite one pixel per motion tick to the target cube, or falls and respawns.
// Latency: 1 cycle to TARGET, then one tick per pixel; busy high outside IDLE.
// Backpressure: requests while busy are dropped, or held one-deep (latest wins) with QBERT_JUMP_QUEUE_EN.
module qbert_jump_ctrl
    import qbert_pkg::*;
#(
    parameter int          N_ROWS   = N_ROWS_DEF,
    parameter logic [10:0] X_TOP    = X_TOP_DEF,
    parameter logic [9:0]  Y_TOP    = Y_TOP_DEF,
    parameter logic [10:0] XDIAG    = XDIAG_DEF,
    parameter logic [9:0]  YDIAG    = YDIAG_DEF,
    parameter int          TICK_DIV = TICK_DIV_DEF,
    parameter logic [10:0] FALL_PIX = FALL_PIX_DEF
) (
    input  logic             clk,
    input  logic             reset,
    qbert_jump_ctrl_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);

    jstate_t     state, state_nxt;
    dir_t        dir_q, start_dir;
    logic        start, tick;
    logic [PW-1:0] presc;
    logic [2:0]  row_q, col_q, trow_q, tcol_q;
    logic [10:0] qx, tx, tx_c, fall_cnt;
    logic [9:0]  qy, ty, ty_c;
    logic [4:0]  trow_c, tcol_c;
    logic        off_c, fall_done;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) presc <= '0;
        else               presc <= presc + PW'(1);
    end

    // Target computed in 5 bits so a step above row/col 0 shows up as a set sign bit.
    always_comb begin
        trow_c = {2'b00, row_q};
        tcol_c = {2'b00, col_q};
        unique case (dir_q)
            UL: begin trow_c = {2'b00, row_q} - 5'd1; tcol_c = {2'b00, col_q} - 5'd1; end
            UR: trow_c = {2'b00, row_q} - 5'd1;
            DL: trow_c = {2'b00, row_q} + 5'd1;
            DR: begin trow_c = {2'b00, row_q} + 5'd1; tcol_c = {2'b00, col_q} + 5'd1; end
        endcase
        off_c = trow_c[4] | tcol_c[4] | (trow_c >= 5'(N_ROWS)) | (tcol_c > trow_c);
    end

    qbert_cube_pos #(.X_TOP(X_TOP), .Y_TOP(Y_TOP), .XDIAG(XDIAG), .YDIAG(YDIAG)) u_target_pos (
        .row (trow_c[2:0]),
        .col (tcol_c[2:0]),
        .x   (tx_c),
        .y   (ty_c)
    );

    assign fall_done = (state == FALL) && (fall_cnt == FALL_PIX);

`ifdef QBERT_JUMP_QUEUE_EN
    logic q_vld;
    dir_t q_dir;

    assign start     = (state == IDLE) && (q_vld || bus.jump_req);
    assign start_dir = q_vld ? q_dir : dir_t'(bus.jump_dir);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_vld <= 1'b0;
            q_dir <= UL;
        end else if (fall_done) begin
            q_vld <= 1'b0;
        end else if (state == IDLE) begin
            // Draining the buffer; a same-cycle request refills it.
            if (q_vld) begin
                q_vld <= bus.jump_req;
                if (bus.jump_req) q_dir <= dir_t'(bus.jump_dir);
            end
        end else if (bus.jump_req) begin
            q_vld <= 1'b1;
            q_dir <= dir_t'(bus.jump_dir);
        end
    end
`else
    assign start     = (state == IDLE) && bus.jump_req;
    assign start_dir = dir_t'(bus.jump_dir);
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = TARGET;
            TARGET:  state_nxt = off_c ? FALL : (is_down(dir_q) ? MOVE_Y : MOVE_X);
            MOVE_Y:  if (qy == ty) state_nxt = is_down(dir_q) ? MOVE_X : LAND;
            MOVE_X:  if (qx == tx) state_nxt = is_down(dir_q) ? LAND : MOVE_Y;
            LAND:    state_nxt = IDLE;
            FALL:    if (fall_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q    <= UL;
            row_q    <= '0;
            col_q    <= '0;
            trow_q   <= '0;
            tcol_q   <= '0;
            qx       <= X_TOP;
            qy       <= Y_TOP;
            tx       <= X_TOP;
            ty       <= Y_TOP;
            fall_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) dir_q <= start_dir;
                TARGET: begin
                    tx       <= tx_c;
                    ty       <= ty_c;
                    trow_q   <= trow_c[2:0];
                    tcol_q   <= tcol_c[2:0];
                    fall_cnt <= '0;
                end
                MOVE_Y: if (qy != ty && tick) qy <= (qy < ty) ? qy + 10'd1 : qy - 10'd1;
                MOVE_X: if (qx != tx && tick) qx <= (qx < tx) ? qx + 11'd1 : qx - 11'd1;
                LAND: begin
                    row_q <= trow_q;
                    col_q <= tcol_q;
                end
                FALL: begin
                    if (fall_done) begin
                        row_q <= '0;
                        col_q <= '0;
                        qx    <= X_TOP;
                        qy    <= Y_TOP;
                    end else if (tick) begin
                        qx       <= qx + 11'd1;
                        fall_cnt <= fall_cnt + 11'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.qbert_x  = qx;
    assign bus.qbert_y  = qy;
    assign bus.cube_row = row_q;
    assign bus.cube_col = col_q;
    assign bus.busy     = (state != IDLE);
    assign bus.landed   = (state == LAND);
    assign bus.fell     = fall_done;
endmodule
